// File: rtl/port_input_conditioner.sv
// Board input conditioning: two-flop synchronizer, per-bit debounce counter,
// and sticky rise/fall event flags that software polls and clears.
module port_input_conditioner #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             clear_en,
  input  logic [WIDTH-1:0] clear_mask,
  output logic [WIDTH-1:0] stable_out,
  output logic [WIDTH-1:0] rise_flag,
  output logic [WIDTH-1:0] fall_flag,
  output logic             change_pulse
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_p0_q, sync_p0_d;
  logic [WIDTH-1:0] sync_p1_q, sync_p1_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             change_q, change_d;

  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] clr;

  // Count resets whenever the synced value agrees with the accepted one, and
  // also on acceptance, so it saturates at CNT_LAST instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] cnt,
                                                   input logic             diff);
    if (!diff || (cnt >= CNT_LAST)) return '0;
    return cnt + CNT_W'(1);
  endfunction

  assign differ = sync_p1_q ^ stable_q;
  assign clr    = clear_en ? clear_mask : '0;

  // Stage p0/p1: synchronizer chain
  always_comb begin
    sync_p0_d = raw_in;
    sync_p1_d = sync_p0_q;
  end

  // Debounce: accept the synced value after DEBOUNCE_CYCLES consecutive disagreements
  always_comb begin
    stable_d = stable_q;
    accept   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i]  = cnt_sat_inc(cnt_q[i], differ[i]);
      accept[i] = differ[i] && (cnt_q[i] == CNT_LAST);
      if (accept[i]) stable_d[i] = sync_p1_q[i];
    end
  end

  // Events: a set on the same edge as a clear takes priority
  always_comb begin
    rise_d   = (rise_q & ~clr) | (stable_d & ~stable_q);
    fall_d   = (fall_q & ~clr) | (~stable_d & stable_q);
    change_d = |(stable_d ^ stable_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0_q <= '0;
      sync_p1_q <= '0;
      stable_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      change_q  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync_p0_q <= sync_p0_d;
      sync_p1_q <= sync_p1_d;
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      change_q  <= change_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign stable_out   = stable_q;
  assign rise_flag    = rise_q;
  assign fall_flag    = fall_q;
  assign change_pulse = change_q;

endmodule

// File: tb/tb_port_input_conditioner.sv
// Directed and randomized bench for port_input_conditioner with DEBOUNCE_CYCLES=4;
// reference model: a bit flips once its last D synced samples all disagree with it.
module tb_port_input_conditioner;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] raw_in;
  logic         clear_en;
  logic [W-1:0] clear_mask;
  logic [W-1:0] stable_out;
  logic [W-1:0] rise_flag;
  logic [W-1:0] fall_flag;
  logic         change_pulse;

  int n_vec = 0;
  int n_err = 0;

  port_input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .raw_in       (raw_in),
    .clear_en     (clear_en),
    .clear_mask   (clear_mask),
    .stable_out   (stable_out),
    .rise_flag    (rise_flag),
    .fall_flag    (fall_flag),
    .change_pulse (change_pulse)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] m_sync1, m_sync2, m_stable, m_rise, m_fall;
  logic         m_change;
  logic [W-1:0] hist [$];

  task automatic m_reset();
    m_sync1  = '0;
    m_sync2  = '0;
    m_stable = '0;
    m_rise   = '0;
    m_fall   = '0;
    m_change = 1'b0;
    hist.delete();
  endtask

  task automatic m_edge();
    logic [W-1:0] nxt;
    logic [W-1:0] clr;
    logic         all_diff;
    if (!rst_n) begin
      m_reset();
      return;
    end
    hist.push_back(m_sync2);
    if (hist.size() > D) void'(hist.pop_front());
    nxt = m_stable;
    if (hist.size() == D) begin
      for (int i = 0; i < W; i++) begin
        all_diff = 1'b1;
        foreach (hist[j]) if (hist[j][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) nxt[i] = ~m_stable[i];
      end
    end
    clr      = clear_en ? clear_mask : '0;
    m_rise   = (m_rise & ~clr) | (nxt & ~m_stable);
    m_fall   = (m_fall & ~clr) | (~nxt & m_stable);
    m_change = |(nxt ^ m_stable);
    m_stable = nxt;
    m_sync2  = m_sync1;
    m_sync1  = raw_in;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".stable"}, stable_out, m_stable);
    chk({tag, ".rise"},   rise_flag,  m_rise);
    chk({tag, ".fall"},   fall_flag,  m_fall);
    chk({tag, ".change"}, {{(W-1){1'b0}}, change_pulse}, {{(W-1){1'b0}}, m_change});
  endtask

  task automatic step(input string tag, input logic [W-1:0] raw, input logic ce,
                      input logic [W-1:0] cm);
    @(negedge clk);
    raw_in     = raw;
    clear_en   = ce;
    clear_mask = cm;
    @(posedge clk);
    m_edge();
    #1;
    chk_model(tag);
  endtask

  task automatic steps(input string tag, input logic [W-1:0] raw, input int n);
    for (int k = 0; k < n; k++) step(tag, raw, 1'b0, '0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".stable0"}, stable_out, '0);
    chk({tag, ".rise0"},   rise_flag,  '0);
    chk({tag, ".fall0"},   fall_flag,  '0);
    chk({tag, ".chg0"},    {{(W-1){1'b0}}, change_pulse}, '0);
  endtask

  initial begin
    logic [W-1:0] cur;
    int           rises3;
    logic         prev3;

    rst_n      = 1'b1;
    raw_in     = 4'hF;
    clear_en   = 1'b0;
    clear_mask = '0;
    m_reset();

    // 1: asynchronous reset, no clock edge involved
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    steps("rst_hold", 4'hF, 2);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step("rst_rel", 4'hF, 1'b0, '0);
      chk_all_zero("rst_rel_quiet");
    end
    step("rst_rel_e5", 4'hF, 1'b0, '0);
    chk("rst_rel_stable_e5", stable_out, 4'hF);

    // Return to all-zero and clear every flag
    steps("settle0", 4'h0, 8);
    step("clr_all", 4'h0, 1'b1, 4'hF);
    chk("clr_all_rise", rise_flag, 4'h0);
    chk("clr_all_fall", fall_flag, 4'h0);

    // 2: clean press on bit 0
    steps("press", 4'h1, 5);
    chk("press_e4_stable", stable_out, 4'h0);
    step("press_e5", 4'h1, 1'b0, '0);
    chk("press_e5_stable", stable_out, 4'h1);
    chk("press_e5_rise", rise_flag, 4'h1);
    chk("press_e5_chg", {3'b0, change_pulse}, 4'h1);
    step("press_e6", 4'h1, 1'b0, '0);
    chk("press_e6_chg", {3'b0, change_pulse}, 4'h0);

    // 3: 3-cycle glitch on bit 2 is rejected
    steps("glitch_hi", 4'h5, 3);
    for (int k = 0; k < 10; k++) begin
      step("glitch_lo", 4'h1, 1'b0, '0);
      chk("glitch_stable", stable_out, 4'h1);
      chk("glitch_chg", {3'b0, change_pulse}, 4'h0);
    end
    chk("glitch_rise", rise_flag, 4'h1);

    // 4: bounce on bit 3, then hold high
    rises3 = 0;
    prev3  = stable_out[3];
    for (int k = 0; k < 12; k++) begin
      step("bounce", ((k / 2) % 2 == 0) ? 4'h9 : 4'h1, 1'b0, '0);
      if (stable_out[3] && !prev3) rises3++;
      prev3 = stable_out[3];
    end
    for (int k = 0; k < 10; k++) begin
      step("bounce_hold", 4'h9, 1'b0, '0);
      if (stable_out[3] && !prev3) rises3++;
      prev3 = stable_out[3];
    end
    chk("bounce_rises", W'(rises3), 4'h1);
    chk("bounce_rise3", {3'b0, rise_flag[3]}, 4'h1);

    // 5: clear behaviour, including set-wins-over-clear
    steps("pre5_zero", 4'h0, 8);
    step("pre5_clr", 4'h0, 1'b1, 4'hF);
    steps("pre5_up", 4'h3, 8);
    chk("pre5_rise", rise_flag, 4'h3);
    step("clr_b0", 4'h3, 1'b1, 4'h1);
    chk("clr_b0_rise", rise_flag, 4'h2);
    step("clr_ign", 4'h3, 1'b0, 4'hF);
    chk("clr_ign_rise", rise_flag, 4'h2);
    steps("b1_down", 4'h1, 8);
    steps("b1_up", 4'h3, 5);
    step("b1_setclr", 4'h3, 1'b1, 4'h2);
    chk("setclr_stable", stable_out, 4'h3);
    chk("setclr_rise1", {3'b0, rise_flag[1]}, 4'h1);

    // 6: asynchronous reset in the middle of a count
    steps("pre6_zero", 4'h0, 8);
    steps("pre6_cnt", 4'h1, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    m_reset();
    steps("rst_mid_hold", 4'h1, 2);
    rst_n = 1'b1;
    steps("rst_mid_rel", 4'h1, 5);
    chk("rst_mid_e4_stable", stable_out, 4'h0);
    step("rst_mid_e5", 4'h1, 1'b0, '0);
    chk("rst_mid_e5_stable", stable_out, 4'h1);
    chk("rst_mid_e5_rise", rise_flag, 4'h1);

    // Randomized traffic against the model
    cur = 4'h1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 5) == 0) cur = W'($urandom);
      step("rand", cur, ($urandom_range(0, 7) == 0), W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
